captura_requisicao: RTL and testbench
=====================================

CAPTURA_REQUISICAO -- requirements
Module: captura_requisicao

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive identical samples needed to accept a button press or release (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles a request stays pending without ACK (range 1..65535, used only when CAPTURA_TIMEOUT_EN is defined).
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port CH_USER, input, 3 bits: user code from the switches, MSB first.
REQ-006 SHALL have port CH_FUNC2, input, 1 bit: function code MSB from the switch.
REQ-007 SHALL have port BTN, input, 2 bits: function code low bits from the buttons; 1 means pressed.
REQ-008 SHALL have port ACK, input, 1 bit: arbiter accepted the pending request.
REQ-009 SHALL have port REQ_VALID, output, 1 bit: a captured request is pending.
REQ-010 SHALL have port REQ_USER, output, 3 bits: latched user code.
REQ-011 SHALL have port REQ_FUNC, output, 3 bits: latched function code {CH_FUNC2, BTN}.
REQ-012 SHALL have port TIMEOUT, output, 1 bit: one-cycle pulse when a pending request is dropped.

Function
REQ-013 SHALL implement the FSM states IDLE, DEBOUNCE, PENDING and RELEASE, with all outputs registered.
REQ-014 IDLE SHALL move to DEBOUNCE when BTN != 00, store BTN as the sample and set the stable count to 1.
REQ-015 DEBOUNCE SHALL increment the count while BTN equals the sample, restart with count 1 and a new sample if BTN changes to another nonzero value, and return to IDLE if BTN is 00.
REQ-016 When the count reaches DEBOUNCE_CYCLES, the block SHALL, on that edge, latch REQ_USER=CH_USER and REQ_FUNC={CH_FUNC2, sample}, set REQ_VALID=1 and enter PENDING.
REQ-017 The latency SHALL be such that REQ_VALID is visible in the cycle after the DEBOUNCE_CYCLES-th identical nonzero sample.
REQ-018 During PENDING, REQ_USER, REQ_FUNC and REQ_VALID SHALL hold constant, regardless of changes on CH_USER, CH_FUNC2 or BTN.
REQ-019 When ACK=1 while REQ_VALID=1, REQ_VALID SHALL go to 0 on the next edge and the FSM SHALL enter RELEASE; REQ_USER and REQ_FUNC SHALL keep their last values.
REQ-020 ACK SHALL be ignored whenever REQ_VALID=0.
REQ-021 RELEASE SHALL return to IDLE only after BTN=00 for DEBOUNCE_CYCLES consecutive cycles; any nonzero BTN SHALL restart that count, so one held press yields exactly one request.
REQ-022 Codes with BTN=00 (000 and 100) SHALL never be issued.
REQ-023 Counters SHALL saturate and never wrap.

Reset
REQ-024 When RST=1 at an edge, the FSM SHALL go to IDLE, REQ_VALID, REQ_USER, REQ_FUNC and TIMEOUT SHALL be 0, and all counters SHALL be 0.
REQ-025 RST SHALL override every other input in any state, including mid-debounce and PENDING; a pending request SHALL be discarded without TIMEOUT.

Configuration
REQ-026 With CAPTURA_TIMEOUT_EN defined, after TIMEOUT_CYCLES cycles in PENDING without ACK, the block SHALL clear REQ_VALID, pulse TIMEOUT=1 for one cycle and enter RELEASE.
REQ-027 If ACK and timeout expiry occur in the same cycle, ACK SHALL win and TIMEOUT SHALL stay 0.
REQ-028 Without CAPTURA_TIMEOUT_EN, PENDING SHALL wait indefinitely and TIMEOUT SHALL be tied to 0.

Structure
REQ-029 Package captura_pkg SHALL hold the state enum (IDLE, DEBOUNCE, PENDING, RELEASE) and the constants USER_W=3 and FUNC_W=3.
REQ-030 Sub-module contador_estavel SHALL provide the saturating stable-sample counter (clear, increment, terminal-count flag), used in DEBOUNCE and in RELEASE.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 CH_USER=101, CH_FUNC2=0, BTN=01 held 4 cycles -> REQ_VALID=1 in the next cycle, REQ_USER=101, REQ_FUNC=001.
REQ-032 BTN bounce 01,00,01,10 then 10 stable 4 cycles -> no request during the bounce, then REQ_FUNC=010 with CH_FUNC2=0.
REQ-033 While PENDING, change CH_USER from 101 to 001 -> REQ_USER stays 101; 1-cycle ACK -> REQ_VALID=0 next cycle; BTN held -> no second request until BTN=00 for 4 cycles and a new press.
REQ-034 RST=1 during DEBOUNCE and during PENDING -> all outputs 0 next cycle, no request emitted afterwards without a fresh press.
REQ-035 With CAPTURA_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ACK -> REQ_VALID drops after 8 PENDING cycles with a 1-cycle TIMEOUT pulse; with ACK on the 8th cycle -> no TIMEOUT pulse.

Source files
------------

// File: rtl/captura_pkg.sv
// Shared types and widths for the request capture block.
package captura_pkg;

  localparam int unsigned USER_W = 3;
  localparam int unsigned FUNC_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PENDING,
    RELEASE
  } estado_t;

endpackage

// File: rtl/contador_estavel.sv
// Saturating stable-sample counter.
// fim flags that the next increment reaches MAX, so callers can act on that same edge.
module contador_estavel #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic fim
);

  localparam logic [W-1:0] MAXV = W'(MAX);
  localparam logic [W-1:0] LIM  = W'(MAX - 1);

  logic [W-1:0] cnt;

  // clr together with inc restarts the count at 1 (first sample of a new run)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt < MAXV)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign fim = (cnt >= LIM);

endmodule

// File: rtl/captura_requisicao.sv
// Debounced button request capture with pending/ack handshake.
// Optional pending timeout enabled by defining CAPTURA_TIMEOUT_EN.
module captura_requisicao
  import captura_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [USER_W-1:0] CH_USER,
  input  logic              CH_FUNC2,
  input  logic [1:0]        BTN,
  input  logic              ACK,
  output logic              REQ_VALID,
  output logic [USER_W-1:0] REQ_USER,
  output logic [FUNC_W-1:0] REQ_FUNC,
  output logic              TIMEOUT
);

  estado_t    estado;
  logic [1:0] amostra;
  logic       d_clr, d_inc, d_fim;

  contador_estavel #(.W(8), .MAX(DEBOUNCE_CYCLES)) u_debounce (
    .clk (CLK),
    .rst (RST),
    .clr (d_clr),
    .inc (d_inc),
    .fim (d_fim)
  );

  // Counter is held at 0 outside DEBOUNCE/RELEASE so d_fim is valid on the first sample
  always_comb begin
    d_clr = 1'b1;
    d_inc = 1'b0;
    unique case (estado)
      IDLE: begin
        d_inc = (BTN != 2'b00) && !d_fim;
      end
      DEBOUNCE: begin
        if (BTN == 2'b00) begin
          d_clr = 1'b1;
        end else if (BTN == amostra) begin
          d_clr = d_fim;
          d_inc = !d_fim;
        end else begin
          d_inc = 1'b1;
        end
      end
      PENDING: begin
        d_clr = 1'b1;
      end
      RELEASE: begin
        if (BTN == 2'b00) begin
          d_clr = d_fim;
          d_inc = !d_fim;
        end
      end
      default: d_clr = 1'b1;
    endcase
  end

`ifdef CAPTURA_TIMEOUT_EN
  logic t_clr, t_inc, t_fim;

  assign t_inc = (estado == PENDING) && !ACK && !t_fim;
  assign t_clr = !t_inc;

  contador_estavel #(.W(16), .MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk (CLK),
    .rst (RST),
    .clr (t_clr),
    .inc (t_inc),
    .fim (t_fim)
  );
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado    <= IDLE;
      amostra   <= '0;
      REQ_VALID <= 1'b0;
      REQ_USER  <= '0;
      REQ_FUNC  <= '0;
      TIMEOUT   <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (BTN != 2'b00) begin
            amostra <= BTN;
            if (d_fim) begin
              REQ_USER  <= CH_USER;
              REQ_FUNC  <= {CH_FUNC2, BTN};
              REQ_VALID <= 1'b1;
              estado    <= PENDING;
            end else begin
              estado <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (BTN == 2'b00) begin
            estado <= IDLE;
          end else if (BTN == amostra) begin
            if (d_fim) begin
              REQ_USER  <= CH_USER;
              REQ_FUNC  <= {CH_FUNC2, amostra};
              REQ_VALID <= 1'b1;
              estado    <= PENDING;
            end
          end else begin
            amostra <= BTN;
          end
        end
        PENDING: begin
          if (ACK) begin
            REQ_VALID <= 1'b0;
            estado    <= RELEASE;
          end
`ifdef CAPTURA_TIMEOUT_EN
          else if (t_fim) begin
            REQ_VALID <= 1'b0;
            TIMEOUT   <= 1'b1;
            estado    <= RELEASE;
          end
`endif
        end
        RELEASE: begin
          if ((BTN == 2'b00) && d_fim) begin
            estado <= IDLE;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_requisicao.sv
// Directed self-checking bench for captura_requisicao (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8).
module tb_captura_requisicao;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ch_user;
  logic       ch_func2;
  logic [1:0] btn;
  logic       ack;
  logic       req_valid;
  logic [2:0] req_user;
  logic [2:0] req_func;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  captura_requisicao #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .CH_USER   (ch_user),
    .CH_FUNC2  (ch_func2),
    .BTN       (btn),
    .ACK       (ack),
    .REQ_VALID (req_valid),
    .REQ_USER  (req_user),
    .REQ_FUNC  (req_func),
    .TIMEOUT   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] user;
    logic       f2;
    logic [1:0] btn;
    logic       ack;
    logic       e_valid;
    logic [2:0] e_user;
    logic [2:0] e_func;
    logic       e_tmo;
  } vec_t;

  vec_t tab[$];

  task automatic add(input int n, input logic r, input logic [2:0] u, input logic f,
                     input logic [1:0] b, input logic a, input logic ev,
                     input logic [2:0] eu, input logic [2:0] ef, input logic et);
    vec_t v;
    v.rst = r; v.user = u; v.f2 = f; v.btn = b; v.ack = a;
    v.e_valid = ev; v.e_user = eu; v.e_func = ef; v.e_tmo = et;
    for (int i = 0; i < n; i++) tab.push_back(v);
  endtask

  task automatic passo(input logic r, input logic [2:0] u, input logic f,
                       input logic [1:0] b, input logic a);
    @(negedge clk);
    rst = r; ch_user = u; ch_func2 = f; btn = b; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checa(input string nome, input logic ev, input logic [2:0] eu,
                       input logic [2:0] ef, input logic et);
    checks++;
    if (req_valid !== ev || req_user !== eu || req_func !== ef || timeout !== et) begin
      errors++;
      $display("FAIL %s: got valid=%b user=%b func=%b timeout=%b, expected valid=%b user=%b func=%b timeout=%b",
               nome, req_valid, req_user, req_func, timeout, ev, eu, ef, et);
    end
  endtask

  initial begin
    rst = 1'b1; ch_user = '0; ch_func2 = 1'b0; btn = '0; ack = 1'b0;

    // basic capture, hold during PENDING, ack, release restart, one request per press
    add(1, 1, 3'b000, 0, 2'b00, 0,  0, 3'b000, 3'b000, 0);
    add(1, 0, 3'b101, 0, 2'b00, 0,  0, 3'b000, 3'b000, 0);
    add(1, 0, 3'b101, 0, 2'b01, 0,  0, 3'b000, 3'b000, 0);
    add(1, 0, 3'b101, 0, 2'b01, 1,  0, 3'b000, 3'b000, 0);
    add(1, 0, 3'b101, 0, 2'b01, 0,  0, 3'b000, 3'b000, 0);
    add(1, 0, 3'b101, 0, 2'b01, 0,  1, 3'b101, 3'b001, 0);
    add(1, 0, 3'b001, 0, 2'b01, 0,  1, 3'b101, 3'b001, 0);
    add(1, 0, 3'b001, 1, 2'b11, 0,  1, 3'b101, 3'b001, 0);
    add(1, 0, 3'b001, 1, 2'b01, 1,  0, 3'b101, 3'b001, 0);
    add(1, 0, 3'b001, 0, 2'b01, 0,  0, 3'b101, 3'b001, 0);
    add(3, 0, 3'b001, 0, 2'b00, 0,  0, 3'b101, 3'b001, 0);
    add(1, 0, 3'b001, 0, 2'b01, 0,  0, 3'b101, 3'b001, 0);
    add(3, 0, 3'b001, 0, 2'b00, 0,  0, 3'b101, 3'b001, 0);
    add(4, 0, 3'b011, 1, 2'b10, 0,  0, 3'b101, 3'b001, 0);
    add(4, 0, 3'b011, 1, 2'b00, 0,  0, 3'b101, 3'b001, 0);
    add(3, 0, 3'b011, 1, 2'b10, 0,  0, 3'b101, 3'b001, 0);
    add(1, 0, 3'b011, 1, 2'b10, 0,  1, 3'b011, 3'b110, 0);
    add(1, 0, 3'b011, 1, 2'b00, 1,  0, 3'b011, 3'b110, 0);
    add(4, 0, 3'b011, 1, 2'b00, 0,  0, 3'b011, 3'b110, 0);
    // bounce 01,00,01,10 then 10 held
    add(1, 0, 3'b110, 0, 2'b01, 0,  0, 3'b011, 3'b110, 0);
    add(1, 0, 3'b110, 0, 2'b00, 0,  0, 3'b011, 3'b110, 0);
    add(1, 0, 3'b110, 0, 2'b01, 0,  0, 3'b011, 3'b110, 0);
    add(3, 0, 3'b110, 0, 2'b10, 0,  0, 3'b011, 3'b110, 0);
    add(1, 0, 3'b110, 0, 2'b10, 0,  1, 3'b110, 3'b010, 0);
    add(1, 0, 3'b110, 0, 2'b10, 1,  0, 3'b110, 3'b010, 0);

    for (int i = 0; i < tab.size(); i++) begin
      passo(tab[i].rst, tab[i].user, tab[i].f2, tab[i].btn, tab[i].ack);
      checa($sformatf("vec%0d", i), tab[i].e_valid, tab[i].e_user, tab[i].e_func, tab[i].e_tmo);
    end

    // reset mid-debounce
    for (int i = 0; i < 4; i++) passo(0, 3'b110, 0, 2'b00, 0);
    checa("release_done", 0, 3'b110, 3'b010, 0);
    for (int i = 0; i < 2; i++) passo(0, 3'b110, 0, 2'b01, 0);
    passo(1, 3'b110, 0, 2'b01, 0);
    checa("rst_debounce", 0, 3'b000, 3'b000, 0);
    for (int i = 0; i < 6; i++) begin
      passo(0, 3'b110, 0, 2'b00, 0);
      checa("post_rst_idle", 0, 3'b000, 3'b000, 0);
    end

    // reset while pending
    for (int i = 0; i < 3; i++) passo(0, 3'b111, 1, 2'b11, 0);
    checa("press_partial", 0, 3'b000, 3'b000, 0);
    passo(0, 3'b111, 1, 2'b11, 0);
    checa("press_111", 1, 3'b111, 3'b111, 0);
    passo(1, 3'b111, 1, 2'b11, 0);
    checa("rst_pending", 0, 3'b000, 3'b000, 0);
    for (int i = 0; i < 6; i++) begin
      passo(0, 3'b111, 1, 2'b00, 0);
      checa("post_rst_pending", 0, 3'b000, 3'b000, 0);
    end

    // pending without ack
    for (int i = 0; i < 4; i++) passo(0, 3'b010, 0, 2'b01, 0);
    checa("press_010", 1, 3'b010, 3'b001, 0);
`ifdef CAPTURA_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      passo(0, 3'b010, 0, 2'b01, 0);
      checa("tmo_wait", 1, 3'b010, 3'b001, 0);
    end
    passo(0, 3'b010, 0, 2'b01, 0);
    checa("tmo_pulse", 0, 3'b010, 3'b001, 1);
    passo(0, 3'b010, 0, 2'b00, 0);
    checa("tmo_pulse_end", 0, 3'b010, 3'b001, 0);
    for (int i = 0; i < 3; i++) passo(0, 3'b100, 1, 2'b00, 0);
    for (int i = 0; i < 4; i++) passo(0, 3'b100, 1, 2'b10, 0);
    checa("press_100", 1, 3'b100, 3'b110, 0);
    for (int i = 0; i < 7; i++) begin
      passo(0, 3'b100, 1, 2'b10, 0);
      checa("ack_race_wait", 1, 3'b100, 3'b110, 0);
    end
    passo(0, 3'b100, 1, 2'b10, 1);
    checa("ack_wins", 0, 3'b100, 3'b110, 0);
    passo(0, 3'b100, 1, 2'b10, 0);
    checa("ack_wins_next", 0, 3'b100, 3'b110, 0);
`else
    for (int i = 0; i < 20; i++) begin
      passo(0, 3'b010, 0, 2'b01, 0);
      checa("no_tmo_wait", 1, 3'b010, 3'b001, 0);
    end
    passo(0, 3'b010, 0, 2'b01, 1);
    checa("late_ack", 0, 3'b010, 3'b001, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
